// File: rtl/ysyx_22050710_axil_master_bridge.sv
// AXI4-Lite master bridge: one valid/ready request at a time becomes an aligned
// AXI-Lite beat with generated strobes; the read data is aligned and extended, and the response is held until consumed.
module ysyx_22050710_axil_master_bridge #(
    parameter int         DATA_WIDTH = 64,
    parameter int         ADDR_WIDTH = 32,
    parameter logic [2:0] AXI_PROT   = 3'b000
) (
    input  logic                    i_aclk,
    input  logic                    i_arsetn,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [1:0]              i_req_size,
    input  logic                    i_req_unsigned,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    output logic                    o_resp_valid,
    input  logic                    i_resp_ready,
    output logic [DATA_WIDTH-1:0]   o_resp_rdata,
    output logic [1:0]              o_resp_status,
    output logic                    o_resp_misalign,
    output logic                    o_awvalid,
    input  logic                    i_awready,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    output logic [2:0]              o_awprot,
    output logic                    o_wvalid,
    input  logic                    i_wready,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb,
    input  logic                    i_bvalid,
    output logic                    o_bready,
    input  logic [1:0]              i_bresp,
    output logic                    o_arvalid,
    input  logic                    i_arready,
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    output logic [2:0]              o_arprot,
    input  logic                    i_rvalid,
    output logic                    o_rready,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic [1:0]              i_rresp
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF_W      = $clog2(STRB_WIDTH);
    localparam int IDX_W      = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    aw_pend_q, aw_pend_d;
    logic                    w_pend_q, w_pend_d;
    logic                    arvalid_q, rready_q, bready_q, resp_valid_q;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              status_q, status_d;
    logic                    misalign_q, misalign_d;
    logic [OFF_W-1:0]        off_s;
    logic                    req_fire_s;

    function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] addr,
                                           input logic [1:0] size);
        case (size)
            2'd0:    is_misaligned = 1'b0;
            2'd1:    is_misaligned = addr[0];
            2'd2:    is_misaligned = |addr[1:0];
            2'd3:    is_misaligned = (DATA_WIDTH == 32) || (|addr[2:0]);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [STRB_WIDTH-1:0] gen_strb(input logic [OFF_W-1:0] off,
                                                       input logic [1:0] size);
        for (int i = 0; i < STRB_WIDTH; i++) begin
            gen_strb[i] = (i >= int'(off)) && (i < int'(off) + (1 << size));
        end
    endfunction

    // Byte lane of interest is shifted down first, then bits above the access width are extended.
    function automatic logic [DATA_WIDTH-1:0] align_read(input logic [DATA_WIDTH-1:0] raw,
                                                         input logic [OFF_W-1:0] off,
                                                         input logic [1:0] size,
                                                         input logic uns);
        logic [DATA_WIDTH-1:0] sh;
        logic [IDX_W-1:0]      msb;
        logic                  sbit;
        sh = raw >> {off, 3'b000};
        case (size)
            2'd0:    msb = IDX_W'(7);
            2'd1:    msb = IDX_W'(15);
            2'd2:    msb = IDX_W'(31);
            default: msb = IDX_W'(DATA_WIDTH - 1);
        endcase
        sbit = uns ? 1'b0 : sh[msb];
        for (int i = 0; i < DATA_WIDTH; i++) begin
            align_read[i] = (i <= int'(msb)) ? sh[i] : sbit;
        end
    endfunction

    assign off_s      = addr_q[OFF_W-1:0];
    assign req_fire_s = o_req_ready && i_req_valid;

    // Next-state, request capture and response capture.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        aw_pend_d  = aw_pend_q;
        w_pend_d   = w_pend_q;
        rdata_d    = rdata_q;
        status_d   = status_q;
        misalign_d = misalign_q;
        case (state_q)
            IDLE: begin
                if (req_fire_s) begin
                    addr_d  = i_req_addr;
                    size_d  = i_req_size;
                    uns_d   = i_req_unsigned;
                    we_d    = i_req_we;
                    wdata_d = i_req_wdata;
                    if (is_misaligned(i_req_addr, i_req_size)) begin
                        state_d    = RESP;
                        rdata_d    = '0;
                        status_d   = 2'b00;
                        misalign_d = 1'b1;
                    end else if (i_req_we) begin
                        state_d   = WR_REQ;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_ADDR: begin
                if (arvalid_q && i_arready) begin
                    state_d = RD_DATA;
                end else begin
                    state_d = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (rready_q && i_rvalid) begin
                    state_d    = RESP;
                    rdata_d    = align_read(i_rdata, off_s, size_q, uns_q);
                    status_d   = i_rresp;
                    misalign_d = 1'b0;
                end else begin
                    state_d = RD_DATA;
                end
            end
            WR_REQ: begin
                aw_pend_d = aw_pend_q && !i_awready;
                w_pend_d  = w_pend_q && !i_wready;
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = WR_RESP;
                end else begin
                    state_d = WR_REQ;
                end
            end
            WR_RESP: begin
                if (bready_q && i_bvalid) begin
                    state_d    = RESP;
                    rdata_d    = '0;
                    status_d   = i_bresp;
                    misalign_d = 1'b0;
                end else begin
                    state_d = WR_RESP;
                end
            end
            RESP: begin
                if (resp_valid_q && i_resp_ready) begin
                    state_d    = IDLE;
                    rdata_d    = '0;
                    status_d   = 2'b00;
                    misalign_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d   = IDLE;
                aw_pend_d = 1'b0;
                w_pend_d  = 1'b0;
            end
        endcase
    end

    // State, capture registers and registered handshake outputs (decoded from next state).
    always_ff @(posedge i_aclk) begin
        if (!i_arsetn) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            aw_pend_q    <= 1'b0;
            w_pend_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            status_q     <= 2'b00;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            aw_pend_q    <= aw_pend_d;
            w_pend_q     <= w_pend_d;
            arvalid_q    <= (state_d == RD_ADDR);
            rready_q     <= (state_d == RD_DATA);
            bready_q     <= (state_d == WR_RESP);
            resp_valid_q <= (state_d == RESP);
            rdata_q      <= rdata_d;
            status_q     <= status_d;
            misalign_q   <= misalign_d;
        end
    end

    assign o_req_ready     = (state_q == IDLE) && i_arsetn;
    assign o_resp_valid    = resp_valid_q;
    assign o_resp_rdata    = rdata_q;
    assign o_resp_status   = status_q;
    assign o_resp_misalign = misalign_q;
    assign o_awvalid       = aw_pend_q;
    assign o_wvalid        = w_pend_q;
    assign o_arvalid       = arvalid_q;
    assign o_rready        = rready_q;
    assign o_bready        = bready_q;
    assign o_awaddr        = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign o_araddr        = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign o_awprot        = AXI_PROT;
    assign o_arprot        = AXI_PROT;
    assign o_wdata         = wdata_q << {off_s, 3'b000};
    assign o_wstrb         = gen_strb(off_s, size_q);

endmodule
